// File: rtl/pll_pwrup_seq_if.sv
// pll_pwrup_seq_if: control, SPI write and regfile write port bundle for the PLL power-up sequencer
interface pll_pwrup_seq_if;
  logic       start;
  logic       abort;
  logic [7:0] step_dly;
  logic       spi_wre;
  logic [7:0] spi_addr;
  logic [7:0] spi_din;
  logic       rf_wre;
  logic [7:0] rf_addr;
  logic [7:0] rf_din;
  logic       busy;
  logic       done;
  logic       conflict;
  modport master (
    output start, abort, step_dly, spi_wre, spi_addr, spi_din,
    input  rf_wre, rf_addr, rf_din, busy, done, conflict
  );
  modport slave (
    input  start, abort, step_dly, spi_wre, spi_addr, spi_din,
    output rf_wre, rf_addr, rf_din, busy, done, conflict
  );
endinterface

// File: rtl/pll_pwrup_seq.sv
// pll_pwrup_seq: steps the analog-enable register through growing bit masks, sharing the regfile port with SPI
module pll_pwrup_seq #(
  parameter logic [7:0] ENA_ADDR = 8'h01,
  parameter int         NSTEP    = 8
) (
  input  logic            clk,
  input  logic            reset,
  pll_pwrup_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, WRITE, WAIT, DONE, OFF} state_t;
  localparam logic [2:0] LAST = 3'(NSTEP - 1);
  state_t     state, nstate;
  logic [2:0] k, nk;
  logic [7:0] cnt, ncnt;
  logic       seq_wr, go;
  logic [8:0] mask;
  // SPI owns the port whenever it writes; the sequencer only fills idle cycles
  assign seq_wr      = !reset && (state == WRITE || state == OFF);
  assign go          = !bus.spi_wre;
  assign mask        = (9'd2 << k) - 9'd1;
  assign bus.rf_wre  = bus.spi_wre | seq_wr;
  assign bus.rf_addr = bus.spi_wre ? bus.spi_addr : seq_wr ? ENA_ADDR : 8'h00;
  assign bus.rf_din  = bus.spi_wre ? bus.spi_din : (seq_wr && state == WRITE) ? mask[7:0] : 8'h00;
  always_comb begin
    nstate = state;
    nk     = k;
    ncnt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          nstate = WRITE;
          nk     = 3'd0;
        end
      end
      WRITE: begin
        if (bus.abort) nstate = OFF;
        else if (go) begin
          if (k == LAST) nstate = DONE;
          else if (bus.step_dly != 8'd0) begin
            nstate = WAIT;
            ncnt   = bus.step_dly;
          end else nk = k + 3'd1;
        end
      end
      WAIT: begin
        if (bus.abort) nstate = OFF;
        else begin
          ncnt = cnt - 8'd1;
          if (cnt <= 8'd1) begin
            nstate = WRITE;
            nk     = k + 3'd1;
          end
        end
      end
      DONE: begin
        if (bus.abort) nstate = OFF;
        else if (bus.start) begin
          nstate = WRITE;
          nk     = 3'd0;
        end
      end
      OFF: begin
        if (go) begin
          nstate = IDLE;
          nk     = 3'd0;
        end
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= 3'd0;
      cnt          <= 8'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.conflict <= 1'b0;
    end else begin
      state        <= nstate;
      k            <= nk;
      cnt          <= ncnt;
      bus.busy     <= !(nstate == IDLE || nstate == DONE);
      bus.done     <= nstate == DONE;
      bus.conflict <= bus.spi_wre && bus.spi_addr == ENA_ADDR && bus.busy;
    end
  end
endmodule

// File: tb/tb_pll_pwrup_seq.sv
// tb_pll_pwrup_seq: directed power-up scenarios plus random traffic against a behavioural sequencer model
module tb_pll_pwrup_seq;
  logic clk = 1'b0;
  logic reset;
  pll_pwrup_seq_if bus ();
  pll_pwrup_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int c; logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t  wl[$];
  int   cl[$];
  int   checks = 0, fails = 0, cyc = 0, t0, t1;
  logic chk_en = 1'b0;
  logic [7:0] masks [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  // model: sequence running, pending power-down, finished, step being written, cycles left before it
  logic m_on, m_off, m_done, m_conf;
  int   m_k, m_gap;
  logic e_seq, e_wre;
  logic [7:0] e_addr, e_din;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  function automatic wr_t ent(int i);
    wr_t e;
    e.c = -1; e.a = 8'hxx; e.d = 8'hxx;
    if (i < wl.size()) e = wl[i];
    return e;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_on = 0; m_off = 0; m_done = 0; m_conf = 0; m_k = 0; m_gap = 0;
    end else begin
      m_conf = bus.spi_wre && bus.spi_addr == 8'h01 && (m_on || m_off);
      if (m_off) begin
        if (!bus.spi_wre) m_off = 0;
      end else if (bus.abort && (m_on || m_done)) begin
        m_on = 0; m_done = 0; m_off = 1;
      end else if (!m_on) begin
        if (bus.start && !bus.abort) begin
          m_on = 1; m_done = 0; m_k = 0; m_gap = 0;
        end
      end else if (m_gap > 0) m_gap--;
      else if (!bus.spi_wre) begin
        if (m_k == 7) begin
          m_on = 0; m_done = 1;
        end else begin
          m_k++; m_gap = int'(bus.step_dly);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      e_seq  = !reset && (m_off || (m_on && m_gap == 0));
      e_wre  = bus.spi_wre || e_seq;
      e_addr = bus.spi_wre ? bus.spi_addr : e_seq ? 8'h01 : 8'h00;
      e_din  = bus.spi_wre ? bus.spi_din : (e_seq && !m_off) ? 8'((1 << (m_k + 1)) - 1) : 8'h00;
      chk("rf_port", {15'd0, bus.rf_wre, bus.rf_addr, bus.rf_din}, {15'd0, e_wre, e_addr, e_din});
      chk("status", {29'd0, bus.busy, bus.done, bus.conflict}, {29'd0, m_on || m_off, m_done, m_conf});
      if (bus.rf_wre) wl.push_back('{cyc, bus.rf_addr, bus.rf_din});
      if (bus.conflict) cl.push_back(cyc);
    end
  end
  initial begin
    reset = 1; bus.start = 0; bus.abort = 0; bus.step_dly = 8'd3;
    bus.spi_wre = 0; bus.spi_addr = 8'h00; bus.spi_din = 8'h00;
    tick;
    chk_en = 1;
    tick;
    chk("rst_status", {29'd0, bus.busy, bus.done, bus.conflict}, 32'd0);
    reset = 0;
    wl.delete();
    bus.start = 1; tick; bus.start = 0; t0 = cyc;
    repeat (36) tick;
    chk("t1_nwr", wl.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", {16'd0, ent(i).a, ent(i).d}, {16'd0, 8'h01, masks[i]});
      chk("t1_cycle", ent(i).c, t0 + 4 * i);
    end
    chk("t1_done", {30'd0, bus.busy, bus.done}, 32'd1);
    wl.delete();
    bus.step_dly = 8'd0;
    bus.start = 1; tick; bus.start = 0; t0 = cyc;
    repeat (10) tick;
    chk("t2_nwr", wl.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", {24'd0, ent(i).d}, {24'd0, masks[i]});
      chk("t2_cycle", ent(i).c, t0 + i);
    end
    wl.delete(); cl.delete();
    bus.step_dly = 8'd3;
    bus.start = 1; tick; bus.start = 0; t0 = cyc;
    repeat (8) tick;
    bus.spi_wre = 1; bus.spi_addr = 8'h10; bus.spi_din = 8'hA5;
    tick; tick;
    bus.spi_wre = 0; bus.spi_addr = 8'h00; bus.spi_din = 8'h00;
    repeat (30) tick;
    chk("t3_spi0", {ent(2).c[15:0], ent(2).a, ent(2).d}, {16'(t0 + 8), 8'h10, 8'hA5});
    chk("t3_spi1", {ent(3).c[15:0], ent(3).a, ent(3).d}, {16'(t0 + 9), 8'h10, 8'hA5});
    chk("t3_retry", {ent(4).c[15:0], ent(4).a, ent(4).d}, {16'(t0 + 10), 8'h01, 8'h07});
    chk("t3_noconf", cl.size(), 0);
    wl.delete(); cl.delete();
    bus.start = 1; tick; bus.start = 0; t0 = cyc;
    repeat (5) tick;
    bus.spi_wre = 1; bus.spi_addr = 8'h01; bus.spi_din = 8'h00;
    tick;
    bus.spi_wre = 0;
    repeat (30) tick;
    chk("t4_spi", {ent(2).c[15:0], ent(2).a, ent(2).d}, {16'(t0 + 5), 8'h01, 8'h00});
    chk("t4_restore", {ent(3).c[15:0], ent(3).a, ent(3).d}, {16'(t0 + 8), 8'h01, 8'h07});
    chk("t4_nconf", cl.size(), 1);
    chk("t4_confcyc", cl.size() > 0 ? cl[0] : -1, t0 + 6);
    wl.delete();
    bus.start = 1; tick; bus.start = 0; t0 = cyc;
    repeat (13) tick;
    bus.abort = 1; tick; bus.abort = 0;
    tick;
    chk("t5_idle", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("t5_nwr", wl.size(), 5);
    chk("t5_0f", {ent(3).c[15:0], ent(3).a, ent(3).d}, {16'(t0 + 12), 8'h01, 8'h0F});
    chk("t5_off", {ent(4).c[15:0], ent(4).a, ent(4).d}, {16'(t0 + 14), 8'h01, 8'h00});
    wl.delete();
    bus.start = 1; bus.abort = 1; tick; bus.start = 0; bus.abort = 0;
    repeat (5) tick;
    chk("t5_sa_nwr", wl.size(), 0);
    chk("t5_sa_busy", {31'd0, bus.busy}, 32'd0);
    wl.delete();
    bus.start = 1; tick; bus.start = 0; t0 = cyc;
    repeat (5) tick;
    reset = 1; tick; reset = 0;
    chk("t6_busy", {31'd0, bus.busy}, 32'd0);
    repeat (10) tick;
    chk("t6_nwr", wl.size(), 2);
    bus.start = 1; tick; bus.start = 0; t1 = cyc;
    tick;
    chk("t6_restart", {ent(2).c[15:0], ent(2).a, ent(2).d}, {16'(t1), 8'h01, 8'h01});
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom % 20) == 0;
      bus.abort    = ($urandom % 40) == 0;
      bus.spi_wre  = ($urandom % 6) == 0;
      bus.spi_addr = ($urandom % 2) != 0 ? 8'h01 : 8'($urandom);
      bus.spi_din  = 8'($urandom);
      if ($urandom % 10 == 0) bus.step_dly = 8'($urandom_range(0, 4));
      reset = ($urandom % 300) == 0;
      tick;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
